// File: rtl/mux_seq_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared types, mode encodings and width helper for mux_seq.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A single-entry range still needs one bit of index/counter.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_seq_if.sv
// ============================================================================
// Module  : mux_seq_if
// Brief   : Channel bus between sample sources (master) and mux_seq (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_seq_if
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SW = clog2_min1(N);

  logic [N*W-1:0] t;
  logic [SW-1:0]  s;
  logic           mode;
  logic           en;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           valid;
  logic           wrap;

  modport master (output t, s, mode, en, input y, ch, valid, wrap);
  modport slave  (input t, s, mode, en, output y, ch, valid, wrap);

endinterface

`default_nettype wire

// File: rtl/mux_seq_scan_ctr.sv
// ============================================================================
// Module  : mux_scan_ctr
// Brief   : Dwell and channel counters for scan mode; ch_scan/wrap describe
//           the channel to present on the coming edge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 50
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     run,
  input  wire logic                     restart,
  output logic [clog2_min1(N)-1:0]      ch_scan,
  output logic                          wrap
);

  localparam int SW = clog2_min1(N);
  localparam int CW = clog2_min1(DWELL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ch_q, ch_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ch_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ch_d  = ch_q;
    wrap  = 1'b0;
    if (restart) begin
      cnt_d = '0;
      ch_d  = '0;
    end else if (run) begin
      if (cnt_q == CW'(DWELL - 1)) begin
        cnt_d = '0;
        if (ch_q == SW'(N - 1)) begin
          ch_d = '0;
          wrap = 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign ch_scan = ch_d;

endmodule

`default_nettype wire

// File: rtl/mux_seq.sv
// ============================================================================
// Module  : mux_seq
// Brief   : Registered N:1 channel multiplexer with manual and auto-scan modes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_seq
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 50
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mux_seq_if.slave   bus
);

  localparam int SW = clog2_min1(N);

  state_e        state_q, state_d;
  logic [W-1:0]  y_q, y_d, y_sel;
  logic [SW-1:0] ch_q, ch_d, ch_next, ch_scan;
  logic          valid_q, valid_d, wrap_q, wrap_d;
  logic          scan_run, scan_restart, scan_wrap, s_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (bus.en) begin
      state_d = (bus.mode == MODE_SCAN) ? SCAN : MANUAL;
    end
  end

  // Manual mode also clears the scan counters, so any later scan entry is fresh.
  assign scan_run     = (state_d == SCAN);
  assign scan_restart = (state_d == MANUAL) || ((state_d == SCAN) && (state_q != SCAN));
  assign s_in_range   = int'(bus.s) < N;

  mux_scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_ctr (
    .clk     (clk),
    .rst     (rst),
    .run     (scan_run),
    .restart (scan_restart),
    .ch_scan (ch_scan),
    .wrap    (scan_wrap)
  );

  always_comb begin
    ch_next = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_d)
      MANUAL: begin
        ch_next = bus.s;
        valid_d = s_in_range;
      end
      SCAN: begin
        ch_next = ch_scan;
        valid_d = 1'b1;
        wrap_d  = scan_wrap;
      end
      default: ;
    endcase

    // Out-of-range indices match no channel and select zero.
    y_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(ch_next) == k) y_sel = bus.t[k*W +: W];
    end

    y_d  = (state_d == IDLE) ? y_q : y_sel;
    ch_d = ch_next;
  end

  assign bus.y     = y_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_seq.sv
// ============================================================================
// Module  : tb_mux_seq
// Brief   : Scoreboard bench for mux_seq (N=4/W=1/DWELL=3 and N=3/W=8/DWELL=1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_seq;

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  mux_seq_if #(.N(4), .W(1)) bus_a ();
  mux_seq_if #(.N(3), .W(8)) bus_b ();

  mux_seq #(.N(4), .W(1), .DWELL(3)) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  mux_seq #(.N(3), .W(8), .DWELL(1)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare(input string tag, input logic [7:0] y, input logic [1:0] ch,
                         input logic v, input logic w);
    exp_t e;
    if (sb.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_val({tag, ".y"},     {24'd0, y},  {24'd0, e.y});
    check_val({tag, ".ch"},    {30'd0, ch}, {30'd0, e.ch});
    check_val({tag, ".valid"}, {31'd0, v},  {31'd0, e.v});
    check_val({tag, ".wrap"},  {31'd0, w},  {31'd0, e.w});
  endtask

  task automatic step_a(input string tag, input logic r, input logic [3:0] t, input logic [1:0] s,
                        input logic mode, input logic en,
                        input logic ey, input logic [1:0] ech, input logic ev, input logic ew);
    @(negedge clk);
    rst_a = r; bus_a.t = t; bus_a.s = s; bus_a.mode = mode; bus_a.en = en;
    sb.push_back('{y: {7'd0, ey}, ch: ech, v: ev, w: ew});
    @(posedge clk); #1;
    compare(tag, {7'd0, bus_a.y}, bus_a.ch, bus_a.valid, bus_a.wrap);
  endtask

  task automatic step_b(input string tag, input logic r, input logic [23:0] t, input logic [1:0] s,
                        input logic mode, input logic en,
                        input logic [7:0] ey, input logic [1:0] ech, input logic ev, input logic ew);
    @(negedge clk);
    rst_b = r; bus_b.t = t; bus_b.s = s; bus_b.mode = mode; bus_b.en = en;
    sb.push_back('{y: ey, ch: ech, v: ev, w: ew});
    @(posedge clk); #1;
    compare(tag, bus_b.y, bus_b.ch, bus_b.valid, bus_b.wrap);
  endtask

  initial begin
    logic [3:0]  pats [4] = '{4'b0011, 4'b1001, 4'b1101, 4'b0100};
    int          scan_ch [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int          tail_ch [11] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
    logic [3:0]  p;
    logic [23:0] tb_words;

    bus_a.t = '0; bus_a.s = '0; bus_a.mode = 1'b0; bus_a.en = 1'b0;
    bus_b.t = '0; bus_b.s = '0; bus_b.mode = 1'b0; bus_b.en = 1'b0;

    // Reset with arbitrary inputs, then idle with all-ones inputs.
    for (int i = 0; i < 2; i++) step_a($sformatf("rst%0d", i), 1'b1, 4'b1010, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step_a($sformatf("idle%0d", i), 1'b0, 4'b1111, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Manual select over the legacy 4:1 vectors.
    for (int k = 0; k < 4; k++) begin
      p = pats[k];
      for (int s = 0; s < 4; s++)
        step_a($sformatf("man_p%0d_s%0d", k, s), 1'b0, p, 2'(s), 1'b0, 1'b1, p[s], 2'(s), 1'b1, 1'b0);
    end

    // Full scan cycle, wrap on return to channel 0.
    p = 4'b0100;
    for (int i = 0; i < 13; i++)
      step_a($sformatf("scan%0d", i), 1'b0, p, 2'd0, 1'b1, 1'b1, p[scan_ch[i]], 2'(scan_ch[i]), 1'b1, (i == 12));
    step_a("scan13", 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    step_a("scan14", 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    step_a("scan15", 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    step_a("scan16", 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    step_a("scan17", 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    step_a("scan18", 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);

    // Pause at ch=2: outputs hold even though t changes.
    for (int i = 0; i < 4; i++) step_a($sformatf("pause%0d", i), 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);

    // Resume restarts at channel 0 with a fresh dwell; run up to ch=3, dwell count 1.
    p = 4'b1000;
    for (int i = 0; i < 11; i++)
      step_a($sformatf("resume%0d", i), 1'b0, p, 2'd0, 1'b1, 1'b1, p[tail_ch[i]], 2'(tail_ch[i]), 1'b1, 1'b0);

    // Mid-scan reset, then scan starts again from channel 0.
    step_a("midrst", 1'b1, p, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step_a($sformatf("postrst%0d", i), 1'b0, p, 2'd0, 1'b1, 1'b1, 1'b0, (i == 3) ? 2'd1 : 2'd0, 1'b1, 1'b0);

    // Scan -> manual switch takes effect on the next edge.
    step_a("to_man", 1'b0, p, 2'd3, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);

    // Second configuration: N=3, W=8, DWELL=1.
    tb_words = {8'hC3, 8'hB2, 8'hA1};
    step_b("b_rst", 1'b1, tb_words, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    step_b("b_man1", 1'b0, tb_words, 2'd1, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b1, 1'b0);
    step_b("b_oor", 1'b0, tb_words, 2'd3, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0);
    step_b("b_scan0", 1'b0, tb_words, 2'd3, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b0);
    step_b("b_scan1", 1'b0, tb_words, 2'd3, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b1, 1'b0);
    step_b("b_scan2", 1'b0, tb_words, 2'd3, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b1, 1'b0);
    step_b("b_scan3", 1'b0, tb_words, 2'd3, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b1);
    step_b("b_scan4", 1'b0, tb_words, 2'd3, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b1, 1'b0);

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
